// File: rtl/uart_frame_rx.sv
// Frame parser behind uart_rx: SOF, LEN, payload, CRC8; buffers payload and reports status/counters.
// Latency: status updates one clock after the final byte (or timeout terminal count); rd_data is 1 clock after rd_addr.
// Backpressure: none upstream; bytes arriving while a finished frame awaits frame_ack are dropped and flagged in overrun.
module uart_frame_rx #(
    parameter int          ADDR_W         = 4,
    parameter int          TIMEOUT_CYCLES = 50_000,
    parameter logic [7:0]  SOF            = 8'h7E
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    input  logic              rx_error,
    input  logic              frame_ack,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [7:0]        rd_data,
    output logic              busy,
    output logic              frame_done,
    output logic              frame_ok,
    output logic [2:0]        err_code,
    output logic [ADDR_W:0]   frame_len,
    output logic              overrun,
    output logic [7:0]        good_cnt,
    output logic [7:0]        bad_cnt
);
    localparam int          MAX_LEN   = 2**ADDR_W;
    localparam int          LW        = ADDR_W + 1;
    localparam int          TW        = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [8:0]  MAX_LEN_W = 9'(MAX_LEN);
    localparam logic [2:0]  ERR_OK    = 3'd0;
    localparam logic [2:0]  ERR_LEN   = 3'd1;
    localparam logic [2:0]  ERR_CRC   = 3'd2;
    localparam logic [2:0]  ERR_UART  = 3'd3;
    localparam logic [2:0]  ERR_TMO   = 3'd4;

    typedef enum logic [2:0] {S_IDLE, S_LEN, S_PAYLOAD, S_CRC, S_DONE} state_t;

    state_t          state_q, state_d;
    logic [7:0]      crc_q, crc_d;
    logic [TW-1:0]   tmo_q, tmo_d;
    logic [LW-1:0]   len_q, len_d;
    logic [LW-1:0]   idx_q, idx_d;
    logic            frame_done_q, frame_done_d;
    logic            frame_ok_q, frame_ok_d;
    logic [2:0]      err_q, err_d;
    logic [LW-1:0]   frame_len_q, frame_len_d;
    logic            overrun_q, overrun_d;
    logic [7:0]      good_q, good_d;
    logic [7:0]      bad_q, bad_d;
    logic [7:0]      rd_data_q;
    logic [7:0]      pay_mem [MAX_LEN];

    logic            accept;
    logic            wr_en;
    logic            fin;
    logic [2:0]      fin_err;
    logic [LW-1:0]   fin_len;

    // MSB-first CRC-8, poly 0x07, one byte per call.
    function automatic logic [7:0] crc8_step(input logic [7:0] c, input logic [7:0] d);
        logic [7:0] r;
        r = c ^ d;
        for (int i = 0; i < 8; i++) begin
            r = r[7] ? ((r << 1) ^ 8'h07) : (r << 1);
        end
        return r;
    endfunction

    assign accept = rx_valid && (state_q != S_DONE);

    // Next-state and status computation; a frame terminates through the fin/fin_err/fin_len triple.
    always_comb begin
        state_d      = state_q;
        crc_d        = crc_q;
        tmo_d        = tmo_q;
        len_d        = len_q;
        idx_d        = idx_q;
        frame_done_d = 1'b0;
        frame_ok_d   = frame_ok_q;
        err_d        = err_q;
        frame_len_d  = frame_len_q;
        overrun_d    = overrun_q;
        good_d       = good_q;
        bad_d        = bad_q;
        wr_en        = 1'b0;
        fin          = 1'b0;
        fin_err      = ERR_OK;
        fin_len      = '0;

        case (state_q)
            S_IDLE: begin
                tmo_d = '0;
                if (accept && !rx_error && rx_data == SOF) begin
                    crc_d   = 8'h00;
                    state_d = S_LEN;
                end
            end
            S_LEN, S_PAYLOAD, S_CRC: begin
                // Length is unknown while still in LEN, so report 0 there.
                fin_len = (state_q == S_LEN) ? '0 : len_q;
                if (accept) begin
                    tmo_d = '0;
                    if (rx_error) begin
                        fin     = 1'b1;
                        fin_err = ERR_UART;
                    end else if (state_q == S_LEN) begin
                        if (rx_data == 8'h00 || {1'b0, rx_data} > MAX_LEN_W) begin
                            fin     = 1'b1;
                            fin_err = ERR_LEN;
                        end else begin
                            len_d   = LW'(rx_data);
                            crc_d   = crc8_step(crc_q, rx_data);
                            idx_d   = '0;
                            state_d = S_PAYLOAD;
                        end
                    end else if (state_q == S_PAYLOAD) begin
                        wr_en = 1'b1;
                        crc_d = crc8_step(crc_q, rx_data);
                        idx_d = idx_q + LW'(1);
                        if (idx_q + LW'(1) == len_q) begin
                            state_d = S_CRC;
                        end
                    end else begin
                        fin     = 1'b1;
                        fin_err = (rx_data == crc_q) ? ERR_OK : ERR_CRC;
                    end
                end else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    fin     = 1'b1;
                    fin_err = ERR_TMO;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            S_DONE: begin
                // Ack wins over a simultaneous byte, leaving overrun clear.
                if (frame_ack) begin
                    state_d    = S_IDLE;
                    frame_ok_d = 1'b0;
                    err_d      = ERR_OK;
                    overrun_d  = 1'b0;
                end else if (rx_valid) begin
                    overrun_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (fin) begin
            state_d      = S_DONE;
            tmo_d        = '0;
            frame_done_d = 1'b1;
            err_d        = fin_err;
            frame_ok_d   = (fin_err == ERR_OK);
            frame_len_d  = fin_len;
            if (fin_err == ERR_OK) begin
                good_d = good_q + 8'd1;
            end else begin
                bad_d = bad_q + 8'd1;
            end
        end
    end

    // State, status and readout registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            crc_q        <= 8'h00;
            tmo_q        <= '0;
            len_q        <= '0;
            idx_q        <= '0;
            frame_done_q <= 1'b0;
            frame_ok_q   <= 1'b0;
            err_q        <= ERR_OK;
            frame_len_q  <= '0;
            overrun_q    <= 1'b0;
            good_q       <= 8'h00;
            bad_q        <= 8'h00;
            rd_data_q    <= 8'h00;
        end else begin
            state_q      <= state_d;
            crc_q        <= crc_d;
            tmo_q        <= tmo_d;
            len_q        <= len_d;
            idx_q        <= idx_d;
            frame_done_q <= frame_done_d;
            frame_ok_q   <= frame_ok_d;
            err_q        <= err_d;
            frame_len_q  <= frame_len_d;
            overrun_q    <= overrun_d;
            good_q       <= good_d;
            bad_q        <= bad_d;
            rd_data_q    <= pay_mem[rd_addr];
        end
    end

    // Payload buffer: no reset so it maps onto plain RAM; contents persist until overwritten.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            pay_mem[idx_q[ADDR_W-1:0]] <= rx_data;
        end
    end

    assign rd_data    = rd_data_q;
    assign busy       = (state_q != S_IDLE);
    assign frame_done = frame_done_q;
    assign frame_ok   = frame_ok_q;
    assign err_code   = err_q;
    assign frame_len  = frame_len_q;
    assign overrun    = overrun_q;
    assign good_cnt   = good_q;
    assign bad_cnt    = bad_q;
endmodule

// File: tb/tb_uart_frame_rx.sv
// Bench for uart_frame_rx: directed byte streams, frame results checked by a scoreboard monitor.
// Stimulus changes 1 time unit after the rising edge; outputs are sampled on the falling edge or #1 after rising.
// Every wait on the design is bounded by a cycle budget.
module tb_uart_frame_rx;
    localparam int ADDR_W = 4;
    localparam int TMO    = 200;

    logic              clk = 1'b0;
    logic              reset;
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              rx_error;
    logic              frame_ack;
    logic [ADDR_W-1:0] rd_addr;
    logic [7:0]        rd_data;
    logic              busy;
    logic              frame_done;
    logic              frame_ok;
    logic [2:0]        err_code;
    logic [ADDR_W:0]   frame_len;
    logic              overrun;
    logic [7:0]        good_cnt;
    logic [7:0]        bad_cnt;

    uart_frame_rx #(.ADDR_W(ADDR_W), .TIMEOUT_CYCLES(TMO), .SOF(8'h7E)) dut (
        .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_error(rx_error), .frame_ack(frame_ack), .rd_addr(rd_addr),
        .rd_data(rd_data), .busy(busy), .frame_done(frame_done),
        .frame_ok(frame_ok), .err_code(err_code), .frame_len(frame_len),
        .overrun(overrun), .good_cnt(good_cnt), .bad_cnt(bad_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        ok;
        logic [2:0]  err;
        logic [4:0]  len;
        logic [7:0]  good;
        logic [7:0]  bad;
    } exp_t;

    exp_t       sb[$];
    int         n_pass  = 0;
    int         n_total = 0;
    int         seen    = 0;
    int         pushed  = 0;
    logic [7:0] m_good  = 8'h00;
    logic [7:0] m_bad   = 8'h00;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    task automatic push_exp(input logic ok, input logic [2:0] err, input logic [4:0] len);
        exp_t e;
        if (err == 3'd0) m_good = m_good + 8'd1;
        else             m_bad  = m_bad + 8'd1;
        e.ok = ok; e.err = err; e.len = len; e.good = m_good; e.bad = m_bad;
        sb.push_back(e);
        pushed++;
    endtask

    // Monitor: every frame_done pulse consumes one scoreboard entry.
    always @(negedge clk) begin
        if (!reset && frame_done) begin
            if (sb.size() == 0) begin
                check("unexpected_frame_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("frame_ok", 32'(frame_ok), 32'(e.ok));
                check("err_code", 32'(err_code), 32'(e.err));
                check("frame_len", 32'(frame_len), 32'(e.len));
                check("good_cnt", 32'(good_cnt), 32'(e.good));
                check("bad_cnt", 32'(bad_cnt), 32'(e.bad));
            end
            seen++;
        end
    end

    task automatic send(input logic [7:0] b, input logic e);
        rx_valid = 1'b1; rx_data = b; rx_error = e;
        @(posedge clk); #1;
        rx_valid = 1'b0; rx_error = 1'b0;
    endtask

    task automatic ack();
        frame_ack = 1'b1;
        @(posedge clk); #1;
        frame_ack = 1'b0;
    endtask

    task automatic wait_frames(input int budget);
        for (int i = 0; i < budget && seen < pushed; i++) @(posedge clk);
        #1;
        check("frame_arrival", 32'(seen), 32'(pushed));
    endtask

    task automatic read_chk(input string name, input logic [ADDR_W-1:0] a, input logic [7:0] exp);
        rd_addr = a;
        @(posedge clk); #1;
        check(name, 32'(rd_data), 32'(exp));
    endtask

    task automatic good_frame();
        send(8'h7E, 1'b0); send(8'h02, 1'b0); send(8'h12, 1'b0); send(8'h34, 1'b0);
        push_exp(1'b1, 3'd0, 5'd2);
        send(8'h27, 1'b0);
        wait_frames(20);
    endtask

    initial begin
        reset = 1'b1; rx_data = 8'h00; rx_valid = 1'b0; rx_error = 1'b0;
        frame_ack = 1'b0; rd_addr = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", 32'(busy), 0);
        check("rst_frame_done", 32'(frame_done), 0);
        check("rst_frame_ok", 32'(frame_ok), 0);
        check("rst_err_code", 32'(err_code), 0);
        check("rst_frame_len", 32'(frame_len), 0);
        check("rst_overrun", 32'(overrun), 0);
        check("rst_good_cnt", 32'(good_cnt), 0);
        check("rst_bad_cnt", 32'(bad_cnt), 0);
        check("rst_rd_data", 32'(rd_data), 0);
        @(posedge clk); #1 reset = 1'b0;
        @(posedge clk); #1;

        // Good frame and readout.
        good_frame();
        read_chk("rd_addr0", 4'd0, 8'h12);
        read_chk("rd_addr1", 4'd1, 8'h34);
        check("busy_in_done", 32'(busy), 1);
        ack();
        check("busy_after_ack", 32'(busy), 0);

        // CRC mismatch.
        send(8'h7E, 1'b0); send(8'h02, 1'b0); send(8'h12, 1'b0); send(8'h34, 1'b0);
        push_exp(1'b0, 3'd2, 5'd2);
        send(8'h28, 1'b0);
        wait_frames(20);
        ack();
        check("busy_after_crc_ack", 32'(busy), 0);

        // Bad LEN: zero, then 17.
        send(8'h7E, 1'b0);
        push_exp(1'b0, 3'd1, 5'd0);
        send(8'h00, 1'b0);
        wait_frames(20);
        ack();
        send(8'h7E, 1'b0);
        push_exp(1'b0, 3'd1, 5'd0);
        send(8'h11, 1'b0);
        wait_frames(20);
        ack();

        // Timeout, then a one-byte good frame.
        send(8'h7E, 1'b0);
        push_exp(1'b0, 3'd4, 5'd1);
        send(8'h01, 1'b0);
        wait_frames(TMO + 20);
        ack();
        send(8'h7E, 1'b0); send(8'h01, 1'b0); send(8'hAA, 1'b0);
        push_exp(1'b1, 3'd0, 5'd1);
        send(8'h4A, 1'b0);
        wait_frames(20);
        read_chk("rd_short_addr0", 4'd0, 8'hAA);
        read_chk("rd_stale_addr1", 4'd1, 8'h34);
        ack();

        // Errored noise in IDLE is ignored; UART error mid-frame aborts.
        send(8'h55, 1'b1);
        send(8'h7E, 1'b1);
        check("busy_after_noise", 32'(busy), 0);
        send(8'h7E, 1'b0); send(8'h02, 1'b0);
        push_exp(1'b0, 3'd3, 5'd2);
        send(8'h12, 1'b1);
        wait_frames(20);
        ack();

        // Overrun in DONE, then ack colliding with a byte.
        good_frame();
        send(8'h7E, 1'b0);
        check("overrun_set", 32'(overrun), 1);
        check("busy_held_done", 32'(busy), 1);
        frame_ack = 1'b1; rx_valid = 1'b1; rx_data = 8'h7E;
        @(posedge clk); #1;
        frame_ack = 1'b0; rx_valid = 1'b0;
        check("overrun_cleared", 32'(overrun), 0);
        check("idle_after_collision", 32'(busy), 0);
        repeat (3) @(posedge clk); #1;
        check("no_frame_from_dropped_sof", 32'(busy), 0);

        // Reset mid-frame clears status and counters.
        send(8'h7E, 1'b0); send(8'h02, 1'b0); send(8'h12, 1'b0);
        reset = 1'b1; #1;
        check("midrst_busy", 32'(busy), 0);
        check("midrst_good", 32'(good_cnt), 0);
        check("midrst_bad", 32'(bad_cnt), 0);
        @(posedge clk); #1 reset = 1'b0;
        m_good = 8'h00; m_bad = 8'h00;

        // 256 good frames wrap good_cnt back to zero.
        for (int f = 0; f < 256; f++) begin
            good_frame();
            ack();
        end
        check("good_cnt_wrapped", 32'(good_cnt), 0);
        check("bad_cnt_after_wrap", 32'(bad_cnt), 0);

        repeat (2) @(posedge clk); #1;
        check("scoreboard_empty", 32'(sb.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
